// File: rtl/block_stepper_pkg.sv
// Shared types and frame-period defaults for the stacker game logic.
package block_stepper_pkg;

    typedef enum logic [1:0] {
        S_MOVE,
        S_PLACE,
        S_OVER,
        S_WIN
    } state_e;

    localparam int FPS_W = 23;

    localparam logic [FPS_W-1:0] FPS_BASE_DEF = 23'd5000000;
    localparam logic [FPS_W-1:0] FPS_STEP_DEF = 23'd300000;
    localparam logic [FPS_W-1:0] FPS_MIN_DEF  = 23'd833332;

endpackage

// File: rtl/block_stepper_overlap_calc.sv
// Overlap of the moving block with the segment placed on the row below.
module overlap_calc #(
    parameter int X_W = 4
) (
    input  logic [X_W-1:0] block_x,
    input  logic [X_W-1:0] block_w,
    input  logic [X_W-1:0] prev_x,
    input  logic [X_W-1:0] prev_w,
    output logic [X_W-1:0] seg_x,
    output logic [X_W-1:0] seg_w,
    output logic           miss
);

    logic [X_W:0] a_lo;
    logic [X_W:0] a_hi;
    logic [X_W:0] b_lo;
    logic [X_W:0] b_hi;
    logic [X_W:0] lo;
    logic [X_W:0] hi;
    logic [X_W:0] diff;

    always_comb begin
        a_lo = {1'b0, block_x};
        b_lo = {1'b0, prev_x};
        a_hi = {1'b0, block_x} + {1'b0, block_w};
        b_hi = {1'b0, prev_x} + {1'b0, prev_w};
        lo   = (a_lo > b_lo) ? a_lo : b_lo;
        hi   = (a_hi < b_hi) ? a_hi : b_hi;
        miss = (hi <= lo);
        diff = hi - lo;
        seg_x = lo[X_W-1:0];
        seg_w = miss ? '0 : diff[X_W-1:0];
    end

endmodule

// File: rtl/block_stepper.sv
// Moving-block sweep, stack placement FSM and per-row frame period.
module block_stepper
    import block_stepper_pkg::*;
#(
    parameter int              COLS       = 10,
    parameter int              ROWS       = 12,
    parameter int              INIT_WIDTH = 3,
    parameter int              X_W        = 4,
    parameter int              Y_W        = 4,
    parameter logic [FPS_W-1:0] FPS_BASE  = FPS_BASE_DEF,
    parameter logic [FPS_W-1:0] FPS_STEP  = FPS_STEP_DEF,
    parameter logic [FPS_W-1:0] FPS_MIN   = FPS_MIN_DEF
) (
    input  logic             clk,
    input  logic             reset_block_stepper,
    input  logic             enable,
    input  logic             enable_frame,
    input  logic             stack,
    output logic [X_W-1:0]   block_x,
    output logic [X_W-1:0]   block_w,
    output logic [Y_W-1:0]   row,
    output logic             placed_valid,
    output logic [X_W-1:0]   placed_x,
    output logic [X_W-1:0]   placed_w,
    output logic [Y_W-1:0]   placed_row,
    output logic             game_over,
    output logic             win,
    output logic [FPS_W-1:0] fps_count
);

    localparam int              PROD_W   = Y_W + FPS_W;
    localparam logic [X_W:0]    COLS_X   = (X_W+1)'(COLS);
    localparam logic [X_W-1:0]  INIT_W   = X_W'(INIT_WIDTH);
    localparam logic [Y_W-1:0]  LAST_ROW = Y_W'(ROWS - 1);
    localparam logic [FPS_W-1:0] FPS_RST =
        (FPS_BASE < FPS_MIN) ? FPS_MIN : FPS_BASE;

    state_e           state_q, state_d;
    logic [X_W-1:0]   block_x_q, block_x_d;
    logic [X_W-1:0]   block_w_q, block_w_d;
    logic [Y_W-1:0]   row_q, row_d;
    logic             dir_right_q, dir_right_d;
    logic [X_W-1:0]   prev_x_q, prev_x_d;
    logic [X_W-1:0]   prev_w_q, prev_w_d;
    logic             placed_valid_q, placed_valid_d;
    logic [X_W-1:0]   placed_x_q, placed_x_d;
    logic [X_W-1:0]   placed_w_q, placed_w_d;
    logic [Y_W-1:0]   placed_row_q, placed_row_d;
    logic             game_over_q, game_over_d;
    logic             win_q, win_d;
    logic             stack_q, stack_d;
    logic [FPS_W-1:0] fps_q, fps_d;

    logic             stack_edge;
    logic [X_W:0]     x_end;
    logic [X_W-1:0]   ov_x;
    logic [X_W-1:0]   ov_w;
    logic             ov_miss;
    logic [X_W-1:0]   seg_x;
    logic [X_W-1:0]   seg_w;
    logic             seg_miss;
    logic [PROD_W-1:0] prod;
    logic [FPS_W-1:0] prod_sat;
    logic [FPS_W-1:0] fps_diff;

    overlap_calc #(.X_W(X_W)) u_overlap (
        .block_x (block_x_q),
        .block_w (block_w_q),
        .prev_x  (prev_x_q),
        .prev_w  (prev_w_q),
        .seg_x   (ov_x),
        .seg_w   (ov_w),
        .miss    (ov_miss)
    );

    assign stack_edge = stack & ~stack_q;
    assign x_end      = {1'b0, block_x_q} + {1'b0, block_w_q};

    // Row 0 has nothing below it, so the whole block is always kept.
    always_comb begin
        if (row_q == '0) begin
            seg_x    = block_x_q;
            seg_w    = block_w_q;
            seg_miss = 1'b0;
        end else begin
            seg_x    = ov_x;
            seg_w    = ov_w;
            seg_miss = ov_miss;
        end
    end

    // Product saturates at the base so the subtraction cannot wrap.
    always_comb begin
        prod = PROD_W'(row_q) * PROD_W'(FPS_STEP);
        if (prod > PROD_W'(FPS_BASE)) begin
            prod_sat = FPS_BASE;
        end else begin
            prod_sat = prod[FPS_W-1:0];
        end
        fps_diff = FPS_BASE - prod_sat;
        fps_d    = (fps_diff < FPS_MIN) ? FPS_MIN : fps_diff;
    end

    always_comb begin
        state_d        = state_q;
        block_x_d      = block_x_q;
        block_w_d      = block_w_q;
        row_d          = row_q;
        dir_right_d    = dir_right_q;
        prev_x_d       = prev_x_q;
        prev_w_d       = prev_w_q;
        placed_valid_d = 1'b0;
        placed_x_d     = placed_x_q;
        placed_w_d     = placed_w_q;
        placed_row_d   = placed_row_q;
        game_over_d    = game_over_q;
        win_d          = win_q;
        stack_d        = stack;

        unique case (state_q)
            S_MOVE: begin
                if (enable && stack_edge) begin
                    state_d = S_PLACE;
                end else if (enable && enable_frame) begin
                    if (dir_right_q) begin
                        if (x_end == COLS_X) begin
                            dir_right_d = 1'b0;
                            block_x_d   = block_x_q - 1'b1;
                        end else begin
                            block_x_d = block_x_q + 1'b1;
                        end
                    end else begin
                        if (block_x_q == '0) begin
                            dir_right_d = 1'b1;
                            block_x_d   = X_W'(1);
                        end else begin
                            block_x_d = block_x_q - 1'b1;
                        end
                    end
                end
            end
            S_PLACE: begin
                if (seg_miss) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    placed_valid_d = 1'b1;
                    placed_x_d     = seg_x;
                    placed_w_d     = seg_w;
                    placed_row_d   = row_q;
                    prev_x_d       = seg_x;
                    prev_w_d       = seg_w;
                    if (row_q == LAST_ROW) begin
                        win_d   = 1'b1;
                        state_d = S_WIN;
                    end else begin
                        row_d       = row_q + 1'b1;
                        block_x_d   = '0;
                        dir_right_d = 1'b1;
                        block_w_d   = seg_w;
                        state_d     = S_MOVE;
                    end
                end
            end
            S_OVER, S_WIN: begin
            end
            default: begin
                state_d = S_MOVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_block_stepper) begin
        if (!reset_block_stepper) begin
            state_q        <= S_MOVE;
            block_x_q      <= '0;
            block_w_q      <= INIT_W;
            row_q          <= '0;
            dir_right_q    <= 1'b1;
            prev_x_q       <= '0;
            prev_w_q       <= INIT_W;
            placed_valid_q <= 1'b0;
            placed_x_q     <= '0;
            placed_w_q     <= '0;
            placed_row_q   <= '0;
            game_over_q    <= 1'b0;
            win_q          <= 1'b0;
            stack_q        <= 1'b1;
            fps_q          <= FPS_RST;
        end else begin
            state_q        <= state_d;
            block_x_q      <= block_x_d;
            block_w_q      <= block_w_d;
            row_q          <= row_d;
            dir_right_q    <= dir_right_d;
            prev_x_q       <= prev_x_d;
            prev_w_q       <= prev_w_d;
            placed_valid_q <= placed_valid_d;
            placed_x_q     <= placed_x_d;
            placed_w_q     <= placed_w_d;
            placed_row_q   <= placed_row_d;
            game_over_q    <= game_over_d;
            win_q          <= win_d;
            stack_q        <= stack_d;
            fps_q          <= fps_d;
        end
    end

    assign block_x      = block_x_q;
    assign block_w      = block_w_q;
    assign row          = row_q;
    assign placed_valid = placed_valid_q;
    assign placed_x     = placed_x_q;
    assign placed_w     = placed_w_q;
    assign placed_row   = placed_row_q;
    assign game_over    = game_over_q;
    assign win          = win_q;
    assign fps_count    = fps_q;

endmodule

// File: tb/tb_block_stepper.sv
// Scoreboard bench for block_stepper: directed sweeps, placements, loss and win.
module tb_block_stepper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        enable_frame = 1'b0;
    logic        stack = 1'b0;

    logic [3:0]  block_x, block_w, placed_x, placed_w;
    logic [3:0]  row, placed_row;
    logic        placed_valid, game_over, win;
    logic [22:0] fps_count;

    logic [3:0]  b_block_x, b_block_w, b_placed_x, b_placed_w;
    logic [3:0]  b_row, b_placed_row;
    logic        b_placed_valid, b_game_over, b_win;
    logic [22:0] b_fps_count;

    typedef struct {
        int x;
        int w;
        int r;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    block_stepper dut (
        .clk                 (clk),
        .reset_block_stepper (rst_n),
        .enable              (enable),
        .enable_frame        (enable_frame),
        .stack               (stack),
        .block_x             (block_x),
        .block_w             (block_w),
        .row                 (row),
        .placed_valid        (placed_valid),
        .placed_x            (placed_x),
        .placed_w            (placed_w),
        .placed_row          (placed_row),
        .game_over           (game_over),
        .win                 (win),
        .fps_count           (fps_count)
    );

    block_stepper #(.FPS_STEP(23'd600000)) dut_fast (
        .clk                 (clk),
        .reset_block_stepper (rst_n),
        .enable              (enable),
        .enable_frame        (enable_frame),
        .stack               (stack),
        .block_x             (b_block_x),
        .block_w             (b_block_w),
        .row                 (b_row),
        .placed_valid        (b_placed_valid),
        .placed_x            (b_placed_x),
        .placed_w            (b_placed_w),
        .placed_row          (b_placed_row),
        .game_over           (b_game_over),
        .win                 (b_win),
        .fps_count           (b_fps_count)
    );

    always @(negedge clk) begin
        if (placed_valid) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL placed_unexpected got x=%0d w=%0d row=%0d want none",
                         placed_x, placed_w, placed_row);
            end else begin
                e = exp_q.pop_front();
                if (placed_x != e.x || placed_w != e.w || placed_row != e.r) begin
                    failures++;
                    $display("FAIL placed_seg got x=%0d w=%0d row=%0d want x=%0d w=%0d row=%0d",
                             placed_x, placed_w, placed_row, e.x, e.w, e.r);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int w, input int r);
        exp_t e;
        e.x = x;
        e.w = w;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk) enable_frame = 1'b1;
        @(negedge clk) enable_frame = 1'b0;
    endtask

    task automatic press();
        @(negedge clk) stack = 1'b1;
        @(negedge clk) stack = 1'b0;
        @(negedge clk);
    endtask

    task automatic goto_x(input int x);
        for (int n = 0; n < 40 && block_x != x; n++) begin
            tick();
        end
        chk("goto_x", 32'(block_x), 32'(x));
    endtask

    task automatic do_reset(input logic hold_stack);
        @(negedge clk);
        stack = hold_stack;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int sweep[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int fast_fps[12] = '{5000000, 4400000, 3800000, 3200000, 2600000,
                         2000000, 1400000, 833332, 833332, 833332,
                         833332, 833332};

    initial begin
        enable = 1'b1;
        do_reset(1'b0);
        chk("rst_block_x", 32'(block_x), 0);
        chk("rst_block_w", 32'(block_w), 3);
        chk("rst_row", 32'(row), 0);
        chk("rst_fps", 32'(fps_count), 5000000);
        chk("rst_flags", {29'd0, placed_valid, game_over, win}, 0);

        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("sweep_%0d", i + 1), 32'(block_x), 32'(sweep[i]));
        end

        goto_x(4);
        push(4, 3, 0);
        press();
        chk("r1_row", 32'(row), 1);
        chk("r1_block_x", 32'(block_x), 0);
        chk("r1_block_w", 32'(block_w), 3);
        @(negedge clk);
        chk("r1_fps", 32'(fps_count), 4700000);

        goto_x(5);
        push(5, 2, 1);
        press();
        chk("r2_row", 32'(row), 2);
        chk("r2_block_w", 32'(block_w), 2);
        press();
        chk("miss_game_over", 32'(game_over), 1);
        chk("miss_row", 32'(row), 2);
        repeat (3) tick();
        chk("over_block_x", 32'(block_x), 0);
        press();
        chk("over_sticky", 32'(game_over), 1);

        do_reset(1'b1);
        repeat (4) tick();
        chk("held_row", 32'(row), 0);
        chk("held_block_x", 32'(block_x), 4);
        stack = 1'b0;
        do_reset(1'b0);

        enable = 1'b0;
        tick();
        chk("dis_block_x", 32'(block_x), 0);
        @(negedge clk) stack = 1'b1;
        @(negedge clk) enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("dis_edge_dropped", 32'(row), 0);
        stack = 1'b0;

        goto_x(3);
        push(3, 3, 0);
        @(negedge clk);
        stack = 1'b1;
        enable_frame = 1'b1;
        @(negedge clk);
        stack = 1'b0;
        enable_frame = 1'b0;
        @(negedge clk);
        chk("frame_edge_row", 32'(row), 1);

        do_reset(1'b0);
        @(negedge clk) stack = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk) stack = 1'b0;
        @(negedge clk);
        chk("midrst_row", 32'(row), 0);
        chk("midrst_valid", 32'(placed_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("fast_rst_fps", 32'(b_fps_count), 5000000);

        for (int r = 0; r < 12; r++) begin
            push(0, 3, r);
            press();
            if (r < 11) begin
                chk($sformatf("win_row_%0d", r), 32'(row), 32'(r + 1));
                chk($sformatf("win_w_%0d", r), 32'(block_w), 3);
                @(negedge clk);
                chk($sformatf("fps_%0d", r + 1), 32'(fps_count),
                    32'(5000000 - 300000 * (r + 1)));
                chk($sformatf("fast_fps_%0d", r + 1), 32'(b_fps_count),
                    32'(fast_fps[r + 1]));
            end
        end
        chk("win_flag", 32'(win), 1);
        chk("win_row", 32'(row), 11);
        chk("win_fps", 32'(fps_count), 1700000);
        chk("win_no_over", 32'(game_over), 0);
        tick();
        press();
        chk("win_hold_x", 32'(block_x), 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
